// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser: FSM states, widths,
// coin values in nickel units and the shortage arithmetic used by CHECK.
package vend_pkg;

  localparam int CNT_W       = 6;
  localparam int AMT_W       = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int TMO_W       = $clog2(TIMEOUT_CYC);

  localparam logic [AMT_W-1:0] NICKEL  = AMT_W'(1);
  localparam logic [AMT_W-1:0] DIME    = AMT_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    EJECT,
    WAIT,
    DONE,
    FAULT
  } state_t;

  // Nickels still owed after paying as many dimes as inventory allows.
  function automatic logic [CNT_W:0] nickels_needed(input logic [AMT_W-1:0] r,
                                                    input logic [CNT_W-1:0] cnt_d);
    logic [CNT_W:0] half;
    logic [CNT_W:0] dimes;
    half  = {{(CNT_W + 1 - AMT_W){1'b0}}, r} >> 1;
    dimes = ({1'b0, cnt_d} < half) ? {1'b0, cnt_d} : half;
    return {{(CNT_W + 1 - AMT_W){1'b0}}, r} - (dimes << 1);
  endfunction

endpackage

// File: rtl/coin_counter.sv
// Inventory counter for one coin denomination: load beats inc/dec, inc and
// dec together cancel, increments saturate at the all-ones count.
module coin_counter
  import vend_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (inc && !dec) begin
      if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change dispenser controller: greedy dime-first payout of a nickel-unit
// amount, one eject per coin-mechanism handshake, with a watchdog on the ack.
module change_dispenser_ctrl
  import vend_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amt,
  output logic             req_ready,
  output logic             eject_n,
  output logic             eject_d,
  input  logic             eject_done,
  input  logic             coin_in_n,
  input  logic             coin_in_d,
  input  logic             load,
  input  logic [CNT_W-1:0] load_n,
  input  logic [CNT_W-1:0] load_d,
  output logic [CNT_W-1:0] cnt_n,
  output logic [CNT_W-1:0] cnt_d,
  output logic             done,
  output logic             short,
  output logic             fault
);

  state_t           state_reg, state_next;
  logic [AMT_W-1:0] r_reg, r_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             short_reg, short_next;
  logic             dec_n, dec_d;
  logic             load_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      tmo_reg   <= '0;
      short_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      tmo_reg   <= tmo_next;
      short_reg <= short_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    tmo_next   = tmo_reg;
    short_next = 1'b0;
    dec_n      = 1'b0;
    dec_d      = 1'b0;
    req_ready  = 1'b0;
    eject_n    = 1'b0;
    eject_d    = 1'b0;
    done       = 1'b0;
    fault      = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          r_next     = req_amt;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (r_reg == '0) begin
          state_next = DONE;
        end else if (nickels_needed(r_reg, cnt_d) > {1'b0, cnt_n}) begin
          short_next = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = EJECT;
        end
      end
      EJECT: begin
        if ((r_reg >= DIME) && (cnt_d != '0)) begin
          eject_d = 1'b1;
          dec_d   = 1'b1;
          r_next  = r_reg - DIME;
        end else begin
          eject_n = 1'b1;
          dec_n   = 1'b1;
          r_next  = r_reg - NICKEL;
        end
        tmo_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (eject_done) begin
          state_next = (r_reg == '0) ? DONE : EJECT;
        end else if (tmo_reg == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_next = FAULT;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign short   = short_reg;
  // Refill is only safe while no payout is in flight.
  assign load_ok = load && (state_reg == IDLE);

  coin_counter u_cnt_n (
    .clk      (clk),
    .rst      (rst),
    .inc      (coin_in_n),
    .dec      (dec_n),
    .load     (load_ok),
    .load_val (load_n),
    .cnt      (cnt_n)
  );

  coin_counter u_cnt_d (
    .clk      (clk),
    .rst      (rst),
    .inc      (coin_in_d),
    .dec      (dec_d),
    .load     (load_ok),
    .load_val (load_d),
    .cnt      (cnt_d)
  );

endmodule
